fifo_wptr_full: RTL and testbench

Write-side pointer and status logic for the async FIFO, in the wclk domain. Consumes the Gray read pointer that the r2w synchronizer has already brought into wclk, as wq2_rptr. Produces the write address for the dual-port RAM and the Gray write pointer for the w2r synchronizer. Also produces full, almost-full, occupancy level and a sticky overflow flag.

---
 rtl/fifo_wptr_full_if.sv | 25 ++
 rtl/fifo_wptr_full.sv | 70 +++++++
 tb/tb_fifo_wptr_full.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wptr_full_if.sv
// Write-side bus of the async FIFO: producer request and sync'd read pointer in,
// RAM address, Gray pointer and status out.
interface fifo_wptr_full_if #(
  parameter int unsigned ASIZE = 4
);
  logic             winc;
  logic             ovf_clr;
  logic [ASIZE:0]   wq2_rptr;
  logic [ASIZE-1:0] waddr;
  logic [ASIZE:0]   wptr;
  logic             wfull;
  logic             walmost_full;
  logic [ASIZE:0]   wlevel;
  logic             wovf;

  modport master (
    output winc, ovf_clr, wq2_rptr,
    input  waddr, wptr, wfull, walmost_full, wlevel, wovf
  );

  modport slave (
    input  winc, ovf_clr, wq2_rptr,
    output waddr, wptr, wfull, walmost_full, wlevel, wovf
  );
endinterface

// File: rtl/fifo_wptr_full.sv
// Async FIFO write-side pointer logic in the wclk domain: binary/Gray write pointer,
// full, almost-full, occupancy and sticky overflow, all registered.
module fifo_wptr_full #(
  parameter int unsigned ASIZE       = 4,
  parameter int unsigned AFULL_LEVEL = 14
) (
  input  logic                 wclk,
  input  logic                 wrst,
  fifo_wptr_full_if.slave      bus
);

  logic [ASIZE:0] wbin_q, wbin_d;
  logic [ASIZE:0] wptr_q, wgray_d;
  logic [ASIZE:0] wlevel_q, wlevel_d;
  logic [ASIZE:0] rbin;
  logic           wfull_q, wfull_d;
  logic           waf_q, waf_d;
  logic           wovf_q, wovf_d;
  logic           wen;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= int'(ASIZE); i++) begin
      rbin[i] = ^(bus.wq2_rptr >> i);
    end
  end

  always_comb begin
    wen      = bus.winc && !wfull_q;
    wbin_d   = wbin_q + (ASIZE + 1)'(wen);
    wgray_d  = wbin_d ^ (wbin_d >> 1);
    wlevel_d = wbin_d - rbin;
    waf_d    = wlevel_d >= (ASIZE + 1)'(AFULL_LEVEL);
    // Full when write pointer is one lap ahead: top two Gray bits inverted.
    wfull_d  = wgray_d == {~bus.wq2_rptr[ASIZE:ASIZE-1], bus.wq2_rptr[ASIZE-2:0]};
    wovf_d   = wovf_q;
    if (bus.winc && wfull_q) begin
      wovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      wovf_d = 1'b0;
    end
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      waf_q    <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wgray_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      waf_q    <= waf_d;
      wovf_q   <= wovf_d;
    end
  end

  assign bus.waddr        = wbin_q[ASIZE-1:0];
  assign bus.wptr         = wptr_q;
  assign bus.wlevel       = wlevel_q;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = waf_q;
  assign bus.wovf         = wovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full (ASIZE=4, AFULL_LEVEL=14).
module tb_fifo_wptr_full;

  typedef struct packed {
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       waf;
    logic [4:0] wlevel;
    logic       wovf;
  } obs_t;

  logic wclk = 1'b0;
  logic wrst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  obs_t sb[$];
  obs_t got, exp;

  // Reference model state
  logic [4:0] m_wbin = '0;
  logic       m_full = 1'b0;
  logic       m_ovf  = 1'b0;

  fifo_wptr_full_if #(.ASIZE(4)) bus ();

  fifo_wptr_full #(.ASIZE(4), .AFULL_LEVEL(14)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  always #5 wclk = ~wclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t sample();
    obs_t s;
    s = {bus.waddr, bus.wptr, bus.wfull, bus.walmost_full, bus.wlevel, bus.wovf};
    return s;
  endfunction

  function automatic obs_t model_step(logic inc, logic [4:0] rb, logic clr);
    logic       wen;
    logic [4:0] nb, lvl;
    obs_t       e;
    wen = inc && !m_full;
    nb  = m_wbin + {4'b0, wen};
    lvl = nb - rb;
    if (inc && m_full) m_ovf = 1'b1;
    else if (clr)      m_ovf = 1'b0;
    m_wbin = nb;
    m_full = (lvl == 5'd16);
    e = {nb[3:0], nb ^ (nb >> 1), lvl == 5'd16, lvl >= 5'd14, lvl, m_ovf};
    return e;
  endfunction

  // Drive one cycle from posedge+1, push the expectation, land at next posedge+1.
  task automatic drive(input logic inc, input logic [4:0] rb, input logic clr);
    bus.winc     = inc;
    bus.wq2_rptr = rb ^ (rb >> 1);
    bus.ovf_clr  = clr;
    sb.push_back(model_step(inc, rb, clr));
    @(posedge wclk);
    #1;
  endtask

  task automatic test_reset();
    got = sample();
    n_cmp++;
    if (got !== obs_t'(0)) begin
      n_err++;
      $display("FAIL reset_init: got %h want %h", got, obs_t'(0));
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd0, 1'b0);
      got = sample();
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL reset_pre[%0d]: got %h want %h", i, got, exp);
      end
    end
    #2 wrst = 1'b1;
    #1;
    got = sample();
    n_cmp++;
    if (got !== obs_t'(0)) begin
      n_err++;
      $display("FAIL reset_async: got %h want %h", got, obs_t'(0));
    end
    bus.winc = 1'b1;
    @(posedge wclk);
    #1;
    got = sample();
    n_cmp++;
    if (got !== obs_t'(0)) begin
      n_err++;
      $display("FAIL reset_hold: got %h want %h", got, obs_t'(0));
    end
    wrst     = 1'b0;
    bus.winc = 1'b0;
    m_wbin   = '0;
    m_full   = 1'b0;
    m_ovf    = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 5'd0, 1'b0);
      got = sample();
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL fill[%0d]: got %h want %h", i, got, exp);
      end
      if (i == 14) begin
        n_cmp++;
        if ({got.wlevel, got.waf} !== {5'd14, 1'b1}) begin
          n_err++;
          $display("FAIL fill_afull: got lvl=%0d af=%b want lvl=14 af=1", got.wlevel, got.waf);
        end
      end
    end
    n_cmp++;
    if ({got.wlevel, got.wfull, got.wptr, got.waddr} !== {5'd16, 1'b1, 5'b11000, 4'd0}) begin
      n_err++;
      $display("FAIL fill_full: got lvl=%0d full=%b wptr=%b waddr=%0d want 16 1 11000 0",
               got.wlevel, got.wfull, got.wptr, got.waddr);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) begin
      drive(i < 3, 5'd0, 1'b0);
      got = sample();
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL ovf_set[%0d]: got %h want %h", i, got, exp);
      end
    end
    n_cmp++;
    if ({got.wptr, got.wovf} !== {5'b11000, 1'b1}) begin
      n_err++;
      $display("FAIL ovf_sticky: got wptr=%b ovf=%b want 11000 1", got.wptr, got.wovf);
    end
    drive(1'b0, 5'd0, 1'b1);
    got = sample();
    exp = sb.pop_front();
    n_cmp++;
    if (got !== exp || got.wovf !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clr: got %h want %h", got, exp);
    end
    drive(1'b1, 5'd0, 1'b1);
    got = sample();
    exp = sb.pop_front();
    n_cmp++;
    if (got !== exp || got.wovf !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_set_wins: got %h want %h", got, exp);
    end
  endtask

  task automatic test_drain();
    drive(1'b0, 5'd1, 1'b0);
    got = sample();
    exp = sb.pop_front();
    n_cmp++;
    if (got !== exp || {got.wfull, got.wlevel, got.waf} !== {1'b0, 5'd15, 1'b1}) begin
      n_err++;
      $display("FAIL drain_1: got %h want %h", got, exp);
    end
    drive(1'b0, 5'd3, 1'b1);
    got = sample();
    exp = sb.pop_front();
    n_cmp++;
    if (got !== exp || {got.wlevel, got.waf} !== {5'd13, 1'b0}) begin
      n_err++;
      $display("FAIL drain_3: got %h want %h", got, exp);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 5'd3, 1'b0);
      got = sample();
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL simul_pre[%0d]: got %h want %h", i, got, exp);
      end
    end
    drive(1'b1, 5'd4, 1'b0);
    got = sample();
    exp = sb.pop_front();
    n_cmp++;
    if (got !== exp || {got.wlevel, got.wfull} !== {5'd15, 1'b0}) begin
      n_err++;
      $display("FAIL simul_wr_rd: got %h want %h", got, exp);
    end
    drive(1'b1, 5'd4, 1'b0);
    got = sample();
    exp = sb.pop_front();
    n_cmp++;
    if (got !== exp || {got.wlevel, got.wfull} !== {5'd16, 1'b1}) begin
      n_err++;
      $display("FAIL simul_to_full: got %h want %h", got, exp);
    end
    // Full plus read advance plus write: write rejected, level drops by one.
    drive(1'b1, 5'd5, 1'b0);
    got = sample();
    exp = sb.pop_front();
    n_cmp++;
    if (got !== exp || {got.wlevel, got.wfull, got.wovf} !== {5'd15, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL simul_full_rej: got %h want %h", got, exp);
    end
  endtask

  task automatic test_wrap();
    logic [4:0] prev_wptr;
    logic       seen_wrap;
    seen_wrap = 1'b0;
    drive(1'b0, m_wbin - 5'd2, 1'b1);
    got = sample();
    exp = sb.pop_front();
    n_cmp++;
    if (got !== exp || got.wlevel !== 5'd2) begin
      n_err++;
      $display("FAIL wrap_setup: got %h want %h", got, exp);
    end
    for (int i = 0; i < 40; i++) begin
      prev_wptr = got.wptr;
      drive(1'b1, m_wbin - 5'd1, 1'b0);
      got = sample();
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp || {got.wlevel, got.wfull} !== {5'd2, 1'b0}) begin
        n_err++;
        $display("FAIL wrap[%0d]: got %h want %h", i, got, exp);
      end
      if (prev_wptr == 5'b10000 && got.wptr == 5'b00000) seen_wrap = 1'b1;
    end
    n_cmp++;
    if (seen_wrap !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_gray: got seen=%b want seen=1 (wptr 10000->00000)", seen_wrap);
    end
  endtask

  initial begin
    bus.winc     = 1'b0;
    bus.ovf_clr  = 1'b0;
    bus.wq2_rptr = '0;
    repeat (2) @(posedge wclk);
    #1 wrst = 1'b0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_simultaneous();
    test_wrap();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
